// File: rtl/wisc_pkg.sv
// Shared encodings for the WISC execute stage: opcodes, branch condition codes,
// flag bit positions and the flag-hazard stall FSM states.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_XOR    = 4'b0010;
    localparam logic [3:0] OP_RED    = 4'b0011;
    localparam logic [3:0] OP_SLL    = 4'b0100;
    localparam logic [3:0] OP_SRA    = 4'b0101;
    localparam logic [3:0] OP_ROR    = 4'b0110;
    localparam logic [3:0] OP_PADDSB = 4'b0111;
    localparam logic [3:0] OP_LW     = 4'b1000;
    localparam logic [3:0] OP_SW     = 4'b1001;
    localparam logic [3:0] OP_LLB    = 4'b1010;
    localparam logic [3:0] OP_LHB    = 4'b1011;
    localparam logic [3:0] OP_B      = 4'b1100;
    localparam logic [3:0] OP_BR     = 4'b1101;
    localparam logic [3:0] OP_PCS    = 4'b1110;
    localparam logic [3:0] OP_HLT    = 4'b1111;

    localparam logic [2:0] CC_NE     = 3'b000;
    localparam logic [2:0] CC_EQ     = 3'b001;
    localparam logic [2:0] CC_GT     = 3'b010;
    localparam logic [2:0] CC_LT     = 3'b011;
    localparam logic [2:0] CC_GE     = 3'b100;
    localparam logic [2:0] CC_LE     = 3'b101;
    localparam logic [2:0] CC_OVFL   = 3'b110;
    localparam logic [2:0] CC_UNCOND = 3'b111;

    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_V = 1;
    localparam int unsigned FLG_N = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } stall_state_t;

endpackage

// File: rtl/flag_branch_unit_if.sv
// Execute/decode bundle between the pipeline (master) and the flag/branch unit (slave).
interface flag_branch_unit_if;
    import wisc_pkg::*;

    logic       ex_valid;
    logic [3:0] ex_opcode;
    logic       alu_N;
    logic       alu_Z;
    logic       alu_V;
    logic       frz;
    logic       br_valid;
    logic [2:0] br_ccc;
    logic [2:0] flags;
    logic       br_taken;
    logic       br_stall;

    modport master (
        output ex_valid, ex_opcode, alu_N, alu_Z, alu_V, frz, br_valid, br_ccc,
        input  flags, br_taken, br_stall
    );

    modport slave (
        input  ex_valid, ex_opcode, alu_N, alu_Z, alu_V, frz, br_valid, br_ccc,
        output flags, br_taken, br_stall
    );

endinterface

// File: rtl/flag_branch_unit_br_cond.sv
// Branch condition evaluator: compares a 3-bit condition code against a {Z,V,N} flag set.
module br_cond
    import wisc_pkg::*;
(
    input  logic [2:0] ccc,
    input  logic [2:0] zvn,
    output logic       taken
);

    logic z;
    logic v;
    logic n;

    always_comb begin
        z     = zvn[FLG_Z];
        v     = zvn[FLG_V];
        n     = zvn[FLG_N];
        taken = 1'b0;
        case (ccc)
            CC_NE:     taken = ~z;
            CC_EQ:     taken = z;
            CC_GT:     taken = ~z & ~n;
            CC_LT:     taken = n;
            CC_GE:     taken = z | (~z & ~n);
            CC_LE:     taken = n | z;
            CC_OVFL:   taken = v;
            CC_UNCOND: taken = 1'b1;
            default:   taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// Execute-stage flag register and branch resolver with flag-hazard handling.
// Define FLAG_BYPASS_EN to forward next-flags to the branch evaluator instead of stalling.
module flag_branch_unit
    import wisc_pkg::*;
(
    input logic              clk,
    input logic              rst,
    flag_branch_unit_if.slave bus
);

    logic [2:0] flags_q;
    logic [2:0] nf;
    logic [2:0] eval_flags;
    logic       writes_nzv;
    logic       writes_z;
    logic       sets_flags;
    logic       hold;
    logic       taken;

    always_comb begin
        writes_nzv = (bus.ex_opcode == OP_ADD) || (bus.ex_opcode == OP_SUB);
        writes_z   = writes_nzv
                     || (bus.ex_opcode == OP_XOR) || (bus.ex_opcode == OP_SLL)
                     || (bus.ex_opcode == OP_SRA) || (bus.ex_opcode == OP_ROR);
        sets_flags = bus.ex_valid & writes_z;

        nf = flags_q;
        if (writes_z) begin
            nf[FLG_Z] = bus.alu_Z;
        end
        if (writes_nzv) begin
            nf[FLG_V] = bus.alu_V;
            nf[FLG_N] = bus.alu_N;
        end
    end

`ifdef FLAG_BYPASS_EN
    // No stall path: a branch paired with a setter sees the forwarded result.
    assign hold         = 1'b0;
    assign bus.br_stall = 1'b0;
    assign eval_flags   = (sets_flags & bus.br_valid) ? nf : flags_q;
`else
    stall_state_t state;
    logic         stall_req;

    assign stall_req    = bus.br_valid & sets_flags & ~bus.frz;
    assign hold         = (state == ST_HOLD);
    assign bus.br_stall = (state == ST_IDLE) & stall_req;
    assign eval_flags   = flags_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else if (!bus.frz) begin
            case (state)
                ST_IDLE: if (stall_req) state <= ST_HOLD;
                ST_HOLD: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
`endif

    // The HOLD cycle carries the stall bubble in EX, so it never writes flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= '0;
        end else if (!bus.frz && sets_flags && !hold) begin
            flags_q <= nf;
        end
    end

    br_cond u_br_cond (
        .ccc   (bus.br_ccc),
        .zvn   (eval_flags),
        .taken (taken)
    );

    assign bus.flags    = flags_q;
    assign bus.br_taken = taken;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Scoreboard bench for flag_branch_unit: directed plan sequences then random traffic,
// checked against a flag/branch reference model (honours FLAG_BYPASS_EN).
module tb_flag_branch_unit;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    flag_branch_unit_if bus ();

    flag_branch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [2:0] flags;
        logic       stall;
        logic       taken;
        logic       chk_taken;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference architectural state.
    bit m_z, m_v, m_n;
    bit m_stalled;

    function automatic bit cond_ok(input bit [2:0] cc, input bit z, input bit v, input bit n);
        case (cc)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || (!z && !n);
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic drive(input bit r, input bit ev, input bit [3:0] op,
                         input bit n, input bit z, input bit v,
                         input bit fz, input bit bv, input bit [2:0] cc);
        bit   full, zonly, sets, nz, nv, nn;
        exp_t e;
        @(posedge clk);
        #1;
        rst           = r;
        bus.ex_valid  = ev;
        bus.ex_opcode = op;
        bus.alu_N     = n;
        bus.alu_Z     = z;
        bus.alu_V     = v;
        bus.frz       = fz;
        bus.br_valid  = bv;
        bus.br_ccc    = cc;

        full  = ev && (op == 4'd0 || op == 4'd1);
        zonly = ev && (op == 4'd2 || op == 4'd4 || op == 4'd5 || op == 4'd6);
        sets  = full || zonly;
        nz = sets ? z : m_z;
        nv = full ? v : m_v;
        nn = full ? n : m_n;

        e.flags = {m_z, m_v, m_n};
`ifdef FLAG_BYPASS_EN
        e.stall = 1'b0;
        e.taken = sets ? cond_ok(cc, nz, nv, nn) : cond_ok(cc, m_z, m_v, m_n);
`else
        e.stall = !m_stalled && bv && sets && !fz;
        e.taken = cond_ok(cc, m_z, m_v, m_n);
`endif
        e.chk_taken = bv && !e.stall;
        exp_q.push_back(e);

        if (r) begin
            {m_z, m_v, m_n} = 3'b000;
            m_stalled = 1'b0;
        end else if (!fz) begin
            if (sets && !m_stalled) begin
                m_z = nz; m_v = nv; m_n = nn;
            end
            m_stalled = e.stall;
        end
    endtask

    // Monitor: every cycle the DUT presents outputs; compare against queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.flags !== e.flags) begin
                    failures++;
                    $display("FAIL flags: got %b expected %b at %0t", bus.flags, e.flags, $time);
                end
                checks++;
                if (bus.br_stall !== e.stall) begin
                    failures++;
                    $display("FAIL br_stall: got %b expected %b at %0t", bus.br_stall, e.stall, $time);
                end
                if (e.chk_taken) begin
                    checks++;
                    if (bus.br_taken !== e.taken) begin
                        failures++;
                        $display("FAIL br_taken: got %b expected %b at %0t", bus.br_taken, e.taken, $time);
                    end
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        bus.ex_valid = 1'b0; bus.ex_opcode = 4'd0;
        bus.alu_N = 1'b0; bus.alu_Z = 1'b0; bus.alu_V = 1'b0;
        bus.frz = 1'b0; bus.br_valid = 1'b0; bus.br_ccc = 3'd0;
        m_z = 1'b0; m_v = 1'b0; m_n = 1'b0; m_stalled = 1'b0;
        @(posedge clk);

        // args: rst ev op N Z V frz br_valid ccc
        drive(1, 0, 4'h0, 0, 0, 0, 0, 1, 3'd7);
        drive(0, 1, 4'h0, 1, 0, 1, 0, 0, 3'd0);   // ADD -> flags 011
        drive(0, 1, 4'h2, 0, 1, 0, 0, 0, 3'd0);   // XOR -> flags 111
        drive(0, 0, 4'h8, 0, 0, 0, 0, 0, 3'd0);
        drive(1, 0, 4'h8, 0, 0, 0, 0, 0, 3'd0);
        drive(0, 1, 4'h1, 0, 1, 0, 0, 1, 3'd1);   // SUB Z=1 with BEQ
        drive(0, 0, 4'h8, 0, 0, 0, 0, 1, 3'd1);   // resolves
        drive(0, 0, 4'h8, 0, 0, 0, 0, 1, 3'd1);   // second branch, no stall
        drive(1, 0, 4'h8, 0, 0, 0, 0, 0, 3'd0);
        drive(0, 1, 4'h8, 0, 1, 0, 0, 1, 3'd2);   // LW + BGT
        drive(0, 1, 4'h8, 0, 1, 0, 0, 1, 3'd5);   // LW + BLE
        drive(0, 1, 4'h7, 0, 1, 0, 0, 1, 3'd7);   // PADDSB
        drive(0, 1, 4'h3, 0, 1, 0, 0, 1, 3'd7);   // RED
        for (int i = 0; i < 3; i++)
            drive(0, 1, 4'h1, 0, 1, 0, 1, 1, 3'd1); // frozen setter + branch
        drive(0, 1, 4'h1, 0, 1, 0, 0, 1, 3'd1);
        drive(0, 0, 4'h8, 0, 0, 0, 0, 1, 3'd1);
        drive(0, 1, 4'h0, 1, 0, 1, 0, 1, 3'd3);   // setter + BLT
        drive(1, 0, 4'h8, 0, 0, 0, 0, 1, 3'd3);   // reset during HOLD
        drive(0, 0, 4'h8, 0, 0, 0, 0, 1, 3'd0);

        for (int i = 0; i < 2000; i++) begin
            drive($urandom_range(0, 59) == 0,
                  $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)),
                  1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 7) == 0,
                  1'($urandom),
                  3'($urandom_range(0, 7)));
        end

        repeat (3) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
